// File: rtl/inst_rom_loader_if.sv
// Loader byte stream and cpu fetch port bundled for the instruction ROM.
// The loader is the slave side; the host/cpu side is the master.
interface inst_rom_loader_if;
    logic        ld_restart;
    logic        ld_valid;
    logic [7:0]  ld_byte;
    logic        ld_ready;
    logic        rom_ce_i;
    logic [31:0] rom_addr_i;
    logic [31:0] rom_data_o;

    modport master (
        output ld_restart, ld_valid, ld_byte, rom_ce_i, rom_addr_i,
        input  ld_ready, rom_data_o
    );

    modport slave (
        input  ld_restart, ld_valid, ld_byte, rom_ce_i, rom_addr_i,
        output ld_ready, rom_data_o
    );
endinterface

// File: rtl/inst_rom_loader.sv
// Instruction ROM that holds the cpu in reset while a host streams a
// length-prefixed, big-endian program in, then serves asynchronous fetches.
module inst_rom_loader #(
    parameter int unsigned AW          = 10,
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    inst_rom_loader_if.slave        bus,
    output logic                    cpu_rst_o,
    output logic                    load_done_o,
    output logic                    load_err_o,
    output logic [15:0]             words_rx_o
);

    localparam int unsigned DEPTH     = 2 ** AW;
    localparam int unsigned HW        = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;
    localparam int unsigned HOLD_INIT = (HOLD_CYCLES > 0) ? HOLD_CYCLES - 1 : 0;

    typedef enum logic [2:0] {
        LEN_HI,
        LEN_LO,
        DATA,
        HOLD,
        RUN
    } state_t;

    state_t         state;
    state_t         state_d;
    logic [15:0]    len;
    logic [15:0]    word_idx;
    logic [1:0]     byte_cnt;
    logic [23:0]    word_buf;
    logic [HW-1:0]  hold_cnt;
    logic           err;
    logic [31:0]    mem [DEPTH];

    logic           accept;
    logic [15:0]    len_full;
    logic           err_set;
    logic           word_done;
    logic           hold_load;
    logic           mem_we;
    logic           unused_addr;

    // Handshake and status decode straight from the state register
    assign bus.ld_ready = (state == LEN_HI) || (state == LEN_LO) || (state == DATA);
    assign cpu_rst_o    = (state != RUN);
    assign load_done_o  = (state == RUN);
    assign load_err_o   = err;
    assign words_rx_o   = word_idx;

    assign accept   = bus.ld_valid & bus.ld_ready;
    assign len_full = {len[15:8], bus.ld_byte};

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= LEN_HI;
        end else begin
            state <= state_d;
        end
    end

    // Next state and datapath strobes
    always_comb begin
        state_d   = state;
        err_set   = 1'b0;
        word_done = 1'b0;
        hold_load = 1'b0;
        unique case (state)
            LEN_HI: begin
                if (accept) begin
                    state_d = LEN_LO;
                end
            end
            LEN_LO: begin
                if (accept) begin
                    err_set = (32'(len_full) > DEPTH);
                    if (len_full == 16'd0) begin
                        state_d   = (HOLD_CYCLES == 0) ? RUN : HOLD;
                        hold_load = 1'b1;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (accept && (byte_cnt == 2'd3)) begin
                    word_done = 1'b1;
                    if (16'(word_idx + 16'd1) == len) begin
                        state_d   = (HOLD_CYCLES == 0) ? RUN : HOLD;
                        hold_load = 1'b1;
                    end
                end
            end
            HOLD: begin
                if (hold_cnt == HW'(0)) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                state_d = RUN;
            end
            default: begin
                state_d = LEN_HI;
            end
        endcase
        // Restart overrides everything below rst; the byte and partial word are lost
        if (bus.ld_restart) begin
            state_d   = LEN_HI;
            err_set   = 1'b0;
            word_done = 1'b0;
            hold_load = 1'b0;
        end
    end

    // Length, byte assembly, word and hold counters
    always_ff @(posedge clk) begin
        if (rst || bus.ld_restart) begin
            len      <= 16'd0;
            word_idx <= 16'd0;
            byte_cnt <= 2'd0;
            word_buf <= 24'd0;
            hold_cnt <= HW'(0);
            err      <= 1'b0;
        end else begin
            if (hold_load) begin
                hold_cnt <= HW'(HOLD_INIT);
            end else if ((state == HOLD) && (hold_cnt != HW'(0))) begin
                hold_cnt <= hold_cnt - HW'(1);
            end
            if (accept) begin
                unique case (state)
                    LEN_HI: len[15:8] <= bus.ld_byte;
                    LEN_LO: len[7:0]  <= bus.ld_byte;
                    DATA: begin
                        byte_cnt <= byte_cnt + 2'd1;
                        word_buf <= {word_buf[15:0], bus.ld_byte};
                    end
                    default: begin
                    end
                endcase
            end
            if (word_done) begin
                word_idx <= word_idx + 16'd1;
            end
            if (err_set) begin
                err <= 1'b1;
            end
        end
    end

    // Words past the end of the array are counted but dropped
    assign mem_we = word_done && !rst && (32'(word_idx) < DEPTH);

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[word_idx[AW-1:0]] <= {word_buf, bus.ld_byte};
        end
    end

    // Asynchronous fetch; byte offset and upper address bits alias
    assign bus.rom_data_o = bus.rom_ce_i ? mem[bus.rom_addr_i[AW+1:2]] : 32'h0;
    assign unused_addr    = ^{bus.rom_addr_i[31:AW+2], bus.rom_addr_i[1:0]};

endmodule

// File: tb/tb_inst_rom_loader.sv
// Three loader instances (large/hold 4, tiny/hold 4, small/hold 0) driven by
// directed and random byte streams, checked every cycle against a stream model.
module tb_inst_rom_loader;

    localparam int NI = 3;
    localparam int DEPTH [NI] = '{1024, 4, 8};
    localparam int HOLD  [NI] = '{4, 4, 0};

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        restart [NI];
    logic        valid   [NI];
    logic [7:0]  byte_v  [NI];
    logic        ce      [NI];
    logic [31:0] addr    [NI];
    logic        ready_o [NI];
    logic [31:0] data_o  [NI];
    logic        cpu_rst_w [NI];
    logic        done_w  [NI];
    logic        err_w   [NI];
    logic [15:0] words_w [NI];

    inst_rom_loader_if b0 ();
    inst_rom_loader_if b1 ();
    inst_rom_loader_if b2 ();

    assign b0.ld_restart = restart[0]; assign b0.ld_valid = valid[0]; assign b0.ld_byte = byte_v[0];
    assign b0.rom_ce_i = ce[0]; assign b0.rom_addr_i = addr[0];
    assign ready_o[0] = b0.ld_ready; assign data_o[0] = b0.rom_data_o;
    assign b1.ld_restart = restart[1]; assign b1.ld_valid = valid[1]; assign b1.ld_byte = byte_v[1];
    assign b1.rom_ce_i = ce[1]; assign b1.rom_addr_i = addr[1];
    assign ready_o[1] = b1.ld_ready; assign data_o[1] = b1.rom_data_o;
    assign b2.ld_restart = restart[2]; assign b2.ld_valid = valid[2]; assign b2.ld_byte = byte_v[2];
    assign b2.rom_ce_i = ce[2]; assign b2.rom_addr_i = addr[2];
    assign ready_o[2] = b2.ld_ready; assign data_o[2] = b2.rom_data_o;

    inst_rom_loader #(.AW(10), .HOLD_CYCLES(4)) u0 (
        .clk(clk), .rst(rst), .bus(b0), .cpu_rst_o(cpu_rst_w[0]),
        .load_done_o(done_w[0]), .load_err_o(err_w[0]), .words_rx_o(words_w[0]));
    inst_rom_loader #(.AW(2), .HOLD_CYCLES(4)) u1 (
        .clk(clk), .rst(rst), .bus(b1), .cpu_rst_o(cpu_rst_w[1]),
        .load_done_o(done_w[1]), .load_err_o(err_w[1]), .words_rx_o(words_w[1]));
    inst_rom_loader #(.AW(3), .HOLD_CYCLES(0)) u2 (
        .clk(clk), .rst(rst), .bus(b2), .cpu_rst_o(cpu_rst_w[2]),
        .load_done_o(done_w[2]), .load_err_o(err_w[2]), .words_rx_o(words_w[2]));

    int total = 0;
    int bad   = 0;

    // Stream-level reference: bytes accepted since restart, completed words, cycles since finish
    int          m_n     [NI];
    int          m_len   [NI];
    int          m_words [NI];
    int          m_since [NI];
    bit          m_done  [NI];
    bit          m_err   [NI];
    logic [31:0] m_buf   [NI];
    logic [31:0] mem_m   [NI][1024];
    bit          wr_m    [NI][1024];

    task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic model_clear(int s);
        m_n[s] = 0; m_len[s] = 0; m_words[s] = 0; m_since[s] = 0;
        m_done[s] = 1'b0; m_err[s] = 1'b0; m_buf[s] = 32'h0;
    endtask

    task automatic model_edge(int s, bit acc, bit rst_v, bit rs_v, logic [7:0] b);
        if (rst_v || rs_v) begin
            model_clear(s);
        end else if (acc) begin
            if (m_n[s] == 0) begin
                m_len[s] = int'(b) * 256;
            end else if (m_n[s] == 1) begin
                m_len[s] = m_len[s] + int'(b);
                if (m_len[s] > DEPTH[s]) m_err[s] = 1'b1;
                if (m_len[s] == 0) begin m_done[s] = 1'b1; m_since[s] = 0; end
            end else begin
                m_buf[s] = {m_buf[s][23:0], b};
                if ((m_n[s] - 2) % 4 == 3) begin
                    if (m_words[s] < DEPTH[s]) begin
                        mem_m[s][m_words[s]] = m_buf[s];
                        wr_m[s][m_words[s]]  = 1'b1;
                    end
                    m_words[s]++;
                    if (m_words[s] == m_len[s]) begin m_done[s] = 1'b1; m_since[s] = 0; end
                end
            end
            m_n[s]++;
        end else if (m_done[s] && m_since[s] < 1000) begin
            m_since[s]++;
        end
    endtask

    task automatic check_status(int s);
        bit run;
        run = m_done[s] && (m_since[s] >= HOLD[s]);
        chk($sformatf("ready%0d", s),   32'(ready_o[s]),   32'(!m_done[s]));
        chk($sformatf("cpu_rst%0d", s), 32'(cpu_rst_w[s]), 32'(!run));
        chk($sformatf("done%0d", s),    32'(done_w[s]),    32'(run));
        chk($sformatf("err%0d", s),     32'(err_w[s]),     32'(m_err[s]));
        chk($sformatf("words%0d", s),   32'(words_w[s]),   32'(16'(m_words[s])));
    endtask

    task automatic cycle();
        bit         acc [NI];
        bit         rs  [NI];
        logic [7:0] bv  [NI];
        bit         rv;
        rv = rst;
        for (int s = 0; s < NI; s++) begin
            acc[s] = valid[s] && !m_done[s];
            rs[s]  = restart[s];
            bv[s]  = byte_v[s];
        end
        @(posedge clk);
        #1;
        for (int s = 0; s < NI; s++) begin
            model_edge(s, acc[s], rv, rs[s], bv[s]);
            check_status(s);
        end
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) cycle();
    endtask

    task automatic send(int s, logic [7:0] b, int gap);
        int g;
        g = (gap > 0) ? int'($urandom_range(gap, 0)) : 0;
        for (int i = 0; i < g; i++) begin
            valid[s] = 1'b0; byte_v[s] = 8'($urandom); cycle();
        end
        valid[s] = 1'b1; byte_v[s] = b; cycle();
        valid[s] = 1'b0;
    endtask

    task automatic send_word(int s, logic [31:0] w, int gap);
        send(s, w[31:24], gap); send(s, w[23:16], gap);
        send(s, w[15:8], gap);  send(s, w[7:0], gap);
    endtask

    task automatic load(int s, int len, int nw, int gap);
        send(s, 8'(len >> 8), gap);
        send(s, 8'(len), gap);
        for (int i = 0; i < nw; i++) send_word(s, $urandom, gap);
    endtask

    task automatic pulse_restart(int s, bit with_byte);
        restart[s] = 1'b1; valid[s] = with_byte; byte_v[s] = 8'($urandom);
        cycle();
        restart[s] = 1'b0; valid[s] = 1'b0;
    endtask

    task automatic rd(int s, logic [31:0] a, logic c, output logic [31:0] d);
        ce[s] = c; addr[s] = a;
        cycle();
        d = data_o[s];
        ce[s] = 1'b0;
    endtask

    // Read every word the model knows about through a randomly aliased address
    task automatic check_mem(int s);
        logic [31:0] a, d;
        for (int i = 0; i < DEPTH[s]; i++) begin
            if (wr_m[s][i]) begin
                a = $urandom;
                a = (a & ~(32'(DEPTH[s] - 1) << 2)) | (32'(i) << 2);
                rd(s, a, 1'b1, d);
                chk($sformatf("mem%0d[%0d]", s, i), d, mem_m[s][i]);
            end
        end
    endtask

    initial begin
        logic [31:0] d;
        for (int s = 0; s < NI; s++) begin
            restart[s] = 1'b0; valid[s] = 1'b0; byte_v[s] = 8'h0;
            ce[s] = 1'b0; addr[s] = 32'h0;
            model_clear(s);
            for (int i = 0; i < 1024; i++) begin wr_m[s][i] = 1'b0; mem_m[s][i] = 32'h0; end
        end

        // Reset
        rst = 1'b1; idle(2);
        rst = 1'b0; idle(1);
        chk("rst_ready", 32'(ready_o[0]), 32'h1);
        chk("rst_cpu_rst", 32'(cpu_rst_w[0]), 32'h1);
        chk("rst_done", 32'(done_w[0]), 32'h0);

        // T1 basic load, hold of 4 cycles
        send(0, 8'h00, 0); send(0, 8'h02, 0);
        send_word(0, 32'h3C010010, 0); send_word(0, 32'h34210005, 0);
        idle(3);
        chk("t1_hold3", 32'(cpu_rst_w[0]), 32'h1);
        idle(1);
        chk("t1_release", 32'(cpu_rst_w[0]), 32'h0);
        chk("t1_done", 32'(done_w[0]), 32'h1);
        chk("t1_words", 32'(words_w[0]), 32'h2);
        rd(0, 32'h4, 1'b1, d); chk("t1_fetch4", d, 32'h34210005);
        rd(0, 32'h0, 1'b1, d); chk("t1_fetch0", d, 32'h3C010010);

        // Same load with no hold releases on the final accept edge
        send(2, 8'h00, 0); send(2, 8'h01, 0); send_word(2, 32'hCAFEF00D, 0);
        chk("t1_nohold", 32'(cpu_rst_w[2]), 32'h0);

        // T2 zero length
        pulse_restart(0, 1'b0);
        send(0, 8'h00, 0); send(0, 8'h00, 0);
        chk("t2_ready", 32'(ready_o[0]), 32'h0);
        chk("t2_words", 32'(words_w[0]), 32'h0);
        idle(5);

        // T3 gaps, then bytes driven in HOLD/RUN must be ignored
        pulse_restart(0, 1'b0);
        load(0, 3, 3, 3);
        for (int i = 0; i < 8; i++) send(0, 8'($urandom), 1);
        check_mem(0);

        // T4 overflow on the 4-word instance
        send(1, 8'h00, 0); send(1, 8'h06, 0);
        chk("t4_err", 32'(err_w[1]), 32'h1);
        for (int i = 0; i < 6; i++) send_word(1, $urandom, 1);
        idle(5);
        chk("t4_words", 32'(words_w[1]), 32'h6);
        chk("t4_run", 32'(done_w[1]), 32'h1);
        check_mem(1);

        // T5 restart mid-word with a byte presented in the restart cycle
        pulse_restart(0, 1'b0);
        send(0, 8'h00, 0); send(0, 8'h02, 0);
        send_word(0, 32'h11223344, 0);
        send(0, 8'h55, 0);
        pulse_restart(0, 1'b1);
        chk("t5_cpu_rst", 32'(cpu_rst_w[0]), 32'h1);
        chk("t5_ready", 32'(ready_o[0]), 32'h1);
        rd(0, 32'h0, 1'b1, d); chk("t5_kept", d, 32'h11223344);
        send(0, 8'h00, 0); send(0, 8'h01, 0);
        send_word(0, 32'hA5A5_5A5A, 0);
        idle(5);
        rd(0, 32'h0, 1'b1, d); chk("t5_over", d, 32'hA5A55A5A);

        // T6 read path and reset while running
        rd(0, 32'h4, 1'b0, d); chk("t6_ce0", d, 32'h0);
        rd(0, 32'h0000_1004, 1'b1, d); chk("t6_alias", d, mem_m[0][1]);
        rd(0, 32'h6, 1'b1, d); chk("t6_low", d, mem_m[0][1]);
        rst = 1'b1; idle(1); rst = 1'b0;
        chk("t6_rst_cpu", 32'(cpu_rst_w[0]), 32'h1);
        check_mem(0);

        // Random loads with random restarts, lengths that may overflow
        for (int it = 0; it < 9; it++) begin
            int s, len, nw;
            s   = it % NI;
            len = int'($urandom_range(10, 0));
            nw  = ($urandom_range(3, 0) == 0) ? int'($urandom_range(len, 0)) : len;
            pulse_restart(s, 1'(($urandom)));
            load(s, len, nw, 2);
            if (nw < len) send(s, 8'($urandom), 0);
            idle(6);
        end
        for (int s = 0; s < NI; s++) check_mem(s);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
